// File: rtl/mem_arbiter_pkg.sv
// Shared RAM command encodings, arbiter state encodings and owner identifiers
// used by the cpu and the memory arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } arb_state_e;

    typedef enum logic {
        OwnCpu = 1'b0,
        OwnIo  = 1'b1
    } owner_e;

    function automatic logic cmd_valid(input logic req, input logic [1:0] cmd);
        return req && (cmd != MNONE);
    endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: one-hot grant from two valids, the last owner
// (0 = requester 0) and a round-robin enable.
module arb_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    input  logic       fair,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (valid0 && valid1) begin
            // On a tie, round-robin hands the port to whoever did not own it last.
            gnt = (fair && !last) ? 2'b10 : 2'b01;
        end else if (valid0) begin
            gnt = 2'b01;
        end else if (valid1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/regLoad.sv
// Load-enabled register with asynchronous active-high clear.
module regLoad #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the cpu and the io master. Whole req/ack transactions
// are serialised as IDLE -> ACCESS (LAT cycles) -> RESP (ack pulse) -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW   = 9,
    parameter int unsigned DW   = 16,
    parameter int unsigned LAT  = 1,
    parameter int unsigned FAIR = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [1:0]    cpu_cmd,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic [1:0]    io_cmd,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_ack,
    output logic [DW-1:0] io_rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] CntInit = 4'(LAT - 1);
    localparam logic       FairEn  = (FAIR != 0);

    arb_state_e state_q;
    owner_e     owner_q;
    owner_e     last_q;
    logic [3:0] cnt_q;
    logic [1:0] pick;
    logic       rd_done;

    arb_pick2 u_pick (
        .valid0 (cmd_valid(cpu_req, cpu_cmd)),
        .valid1 (cmd_valid(io_req, io_cmd)),
        .last   (last_q == OwnIo),
        .fair   (FairEn),
        .gnt    (pick)
    );

    // Final ACCESS cycle of a read: RAM data is valid and goes to the owner's port.
    assign rd_done = (state_q == StAccess) && (cnt_q == 4'd0) && (mem_cmd == MREAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= OwnCpu;
            last_q    <= OwnIo;
            cnt_q     <= 4'd0;
            mem_cmd   <= MNONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_gnt   <= 1'b0;
            io_gnt    <= 1'b0;
            cpu_ack   <= 1'b0;
            io_ack    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick != 2'b00) begin
                        owner_q   <= pick[1] ? OwnIo : OwnCpu;
                        mem_cmd   <= pick[1] ? io_cmd : cpu_cmd;
                        mem_addr  <= pick[1] ? io_addr : cpu_addr;
                        mem_wdata <= pick[1] ? io_wdata : cpu_wdata;
                        cnt_q     <= CntInit;
                        cpu_gnt   <= pick[0];
                        io_gnt    <= pick[1];
                        state_q   <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        mem_cmd <= MNONE;
                        cpu_ack <= (owner_q == OwnCpu);
                        io_ack  <= (owner_q == OwnIo);
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    cpu_ack <= 1'b0;
                    io_ack  <= 1'b0;
                    cpu_gnt <= 1'b0;
                    io_gnt  <= 1'b0;
                    last_q  <= owner_q;
                    state_q <= StIdle;
                end
                default: begin
                    mem_cmd <= MNONE;
                    cpu_ack <= 1'b0;
                    io_ack  <= 1'b0;
                    cpu_gnt <= 1'b0;
                    io_gnt  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    regLoad #(.W(DW)) u_cpu_rdata (
        .clk   (clk),
        .reset (reset),
        .load  (rd_done && (owner_q == OwnCpu)),
        .d     (mem_rdata),
        .q     (cpu_rdata)
    );

    regLoad #(.W(DW)) u_io_rdata (
        .clk   (clk),
        .reset (reset),
        .load  (rd_done && (owner_q == OwnIo)),
        .d     (mem_rdata),
        .q     (io_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations share one stimulus stream and are
// checked every cycle against a transaction-level model plus directed literals.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NI = 3;

    // Instance 0: LAT 1 round-robin, 1: LAT 1 fixed priority, 2: LAT 3 round-robin.
    function automatic int lat_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic int fair_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic logic [15:0] init_word(input int a);
        if (a == 5) return 16'hABCD;
        if (a == 1) return 16'h1111;
        if (a == 2) return 16'h2222;
        return 16'(a) ^ 16'h5A00;
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, io_req;
    logic [1:0]  cpu_cmd, io_cmd;
    logic [8:0]  cpu_addr, io_addr;
    logic [15:0] cpu_wdata, io_wdata;

    wire  [1:0]  mem_cmd_w   [NI];
    wire  [8:0]  mem_addr_w  [NI];
    wire  [15:0] mem_wdata_w [NI];
    wire  [15:0] mem_rdata_w [NI];
    wire  [15:0] cpu_rdata_w [NI];
    wire  [15:0] io_rdata_w  [NI];
    wire         cpu_gnt_w   [NI];
    wire         io_gnt_w    [NI];
    wire         cpu_ack_w   [NI];
    wire         io_ack_w    [NI];

    logic [15:0] ram [NI][512];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arbiter #(
            .AW   (9),
            .DW   (16),
            .LAT  (lat_of(g)),
            .FAIR (fair_of(g))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (cpu_req),
            .cpu_cmd   (cpu_cmd),
            .cpu_addr  (cpu_addr),
            .cpu_wdata (cpu_wdata),
            .cpu_gnt   (cpu_gnt_w[g]),
            .cpu_ack   (cpu_ack_w[g]),
            .cpu_rdata (cpu_rdata_w[g]),
            .io_req    (io_req),
            .io_cmd    (io_cmd),
            .io_addr   (io_addr),
            .io_wdata  (io_wdata),
            .io_gnt    (io_gnt_w[g]),
            .io_ack    (io_ack_w[g]),
            .io_rdata  (io_rdata_w[g]),
            .mem_cmd   (mem_cmd_w[g]),
            .mem_addr  (mem_addr_w[g]),
            .mem_wdata (mem_wdata_w[g]),
            .mem_rdata (mem_rdata_w[g])
        );
        assign mem_rdata_w[g] = ram[g][mem_addr_w[g]];
    end

    initial forever #5 clk = ~clk;

    // RAM behind each instance; writes land mid-cycle while mem_cmd is stable.
    initial begin
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 512; a++) ram[k][a] = init_word(a);
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++)
                if (mem_cmd_w[k] == MWRITE) ram[k][mem_addr_w[k]] = mem_wdata_w[k];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a granted transaction occupies phases 1..LAT (RAM access),
    // phase LAT+1 (ack) and is retired after that; arbitration only while not busy.
    logic        m_busy [NI];
    int          m_ph   [NI];
    logic        m_own  [NI];   // 0 = cpu, 1 = io
    logic        m_last [NI];
    logic [1:0]  m_cmd  [NI];
    logic [8:0]  m_addr [NI];
    logic [15:0] m_wd   [NI];
    logic [15:0] m_rd   [NI][2];
    logic [15:0] sh     [NI][512];

    task automatic model_reset(input int k);
        m_busy[k]  = 1'b0;
        m_ph[k]    = 0;
        m_own[k]   = 1'b0;
        m_last[k]  = 1'b1;
        m_cmd[k]   = MNONE;
        m_addr[k]  = '0;
        m_wd[k]    = '0;
        m_rd[k][0] = '0;
        m_rd[k][1] = '0;
    endtask

    task automatic model_step(input int k);
        logic cv, iv, win_io;
        cv = cpu_req && (cpu_cmd != MNONE);
        iv = io_req && (io_cmd != MNONE);
        if (!m_busy[k]) begin
            if (cv || iv) begin
                win_io    = iv && (!cv || (fair_of(k) == 1 && m_last[k] == 1'b0));
                m_busy[k] = 1'b1;
                m_ph[k]   = 1;
                m_own[k]  = win_io;
                m_cmd[k]  = win_io ? io_cmd : cpu_cmd;
                m_addr[k] = win_io ? io_addr : cpu_addr;
                m_wd[k]   = win_io ? io_wdata : cpu_wdata;
            end
        end else begin
            m_ph[k]++;
            if (m_ph[k] == lat_of(k) + 1) begin
                if (m_cmd[k] == MREAD) m_rd[k][m_own[k]] = sh[k][m_addr[k]];
                else sh[k][m_addr[k]] = m_wd[k];
            end
            if (m_ph[k] == lat_of(k) + 2) begin
                m_busy[k] = 1'b0;
                m_last[k] = m_own[k];
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 512; a++) sh[k][a] = init_word(a);
            model_reset(k);
        end
        forever begin
            @(posedge clk or posedge reset);
            for (int k = 0; k < NI; k++) begin
                if (reset) model_reset(k);
                else model_step(k);
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    initial begin
        logic acc, rsp;
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < NI; k++) begin
                acc = m_busy[k] && (m_ph[k] <= lat_of(k));
                rsp = m_busy[k] && (m_ph[k] == lat_of(k) + 1);
                check($sformatf("k%0d mem_cmd", k), 32'(mem_cmd_w[k]), 32'(acc ? m_cmd[k] : MNONE));
                check($sformatf("k%0d mem_addr", k), 32'(mem_addr_w[k]), 32'(m_addr[k]));
                check($sformatf("k%0d mem_wdata", k), 32'(mem_wdata_w[k]), 32'(m_wd[k]));
                check($sformatf("k%0d cpu_gnt", k), 32'(cpu_gnt_w[k]), 32'(m_busy[k] && !m_own[k]));
                check($sformatf("k%0d io_gnt", k), 32'(io_gnt_w[k]), 32'(m_busy[k] && m_own[k]));
                check($sformatf("k%0d cpu_ack", k), 32'(cpu_ack_w[k]), 32'(rsp && !m_own[k]));
                check($sformatf("k%0d io_ack", k), 32'(io_ack_w[k]), 32'(rsp && m_own[k]));
                check($sformatf("k%0d cpu_rdata", k), 32'(cpu_rdata_w[k]), 32'(m_rd[k][0]));
                check($sformatf("k%0d io_rdata", k), 32'(io_rdata_w[k]), 32'(m_rd[k][1]));
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_cmd = MNONE; cpu_addr = '0; cpu_wdata = '0;
        io_req  = 1'b0; io_cmd  = MNONE; io_addr  = '0; io_wdata  = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        nxt();
        nxt();
        check("reset mem_cmd", 32'(mem_cmd_w[0]), 32'(MNONE));
        check("reset cpu_gnt", 32'(cpu_gnt_w[0]), 32'd0);
        check("reset io_rdata", 32'(io_rdata_w[0]), 32'd0);
        reset = 1'b0;

        // Single cpu read of address 5.
        nxt();
        cpu_req = 1'b1; cpu_cmd = MREAD; cpu_addr = 9'h005;
        nxt();
        check("rd mem_cmd c1", 32'(mem_cmd_w[0]), 32'(MREAD));
        check("rd mem_addr c1", 32'(mem_addr_w[0]), 32'h005);
        check("rd cpu_gnt c1", 32'(cpu_gnt_w[0]), 32'd1);
        nxt();
        check("rd cpu_ack c2", 32'(cpu_ack_w[0]), 32'd1);
        check("rd cpu_rdata c2", 32'(cpu_rdata_w[0]), 32'hABCD);
        check("rd io_rdata c2", 32'(io_rdata_w[0]), 32'd0);
        cpu_req = 1'b0; cpu_cmd = MNONE;
        repeat (6) nxt();

        // io writes 0x1234 to 0x010, then reads it back with req held through the ack.
        io_req = 1'b1; io_cmd = MWRITE; io_addr = 9'h010; io_wdata = 16'h1234;
        nxt();
        check("wr mem_cmd c1", 32'(mem_cmd_w[0]), 32'(MWRITE));
        check("wr mem_wdata c1", 32'(mem_wdata_w[0]), 32'h1234);
        nxt();
        check("wr io_ack c2", 32'(io_ack_w[0]), 32'd1);
        io_cmd = MREAD;
        nxt();
        nxt();
        nxt();
        check("wr rd io_ack c5", 32'(io_ack_w[0]), 32'd1);
        check("wr rd io_rdata c5", 32'(io_rdata_w[0]), 32'h1234);
        io_req = 1'b0; io_cmd = MNONE;
        repeat (6) nxt();

        // Reset during ACCESS of a cpu write.
        cpu_req = 1'b1; cpu_cmd = MWRITE; cpu_addr = 9'h020; cpu_wdata = 16'hBEEF;
        nxt();
        check("mid mem_cmd before", 32'(mem_cmd_w[0]), 32'(MWRITE));
        reset = 1'b1;
        cpu_req = 1'b0; cpu_cmd = MNONE;
        #1;
        check("mid mem_cmd", 32'(mem_cmd_w[0]), 32'(MNONE));
        check("mid cpu_gnt", 32'(cpu_gnt_w[0]), 32'd0);
        check("mid cpu_rdata", 32'(cpu_rdata_w[0]), 32'd0);
        check("mid io_rdata", 32'(io_rdata_w[0]), 32'd0);
        nxt();
        reset = 1'b0;

        // Contention: both hold reads; cpu drops after its fourth fixed-priority ack.
        nxt();
        cpu_req = 1'b1; cpu_cmd = MREAD; cpu_addr = 9'h001;
        io_req  = 1'b1; io_cmd  = MREAD; io_addr  = 9'h002;
        for (int c = 1; c <= 14; c++) begin
            nxt();
            if (c == 1) check("rr first tie cpu_gnt", 32'(cpu_gnt_w[0]), 32'd1);
            if (c == 2) check("rr cpu_ack c2", 32'(cpu_ack_w[0]), 32'd1);
            if (c == 5) begin
                check("rr io_ack c5", 32'(io_ack_w[0]), 32'd1);
                check("rr io_rdata c5", 32'(io_rdata_w[0]), 32'h2222);
                check("fp cpu_ack c5", 32'(cpu_ack_w[1]), 32'd1);
                check("fp io_gnt c5", 32'(io_gnt_w[1]), 32'd0);
            end
            if (c == 8) check("rr cpu_ack c8", 32'(cpu_ack_w[0]), 32'd1);
            if (c == 11) begin
                check("fp cpu_ack c11", 32'(cpu_ack_w[1]), 32'd1);
                cpu_req = 1'b0; cpu_cmd = MNONE;
            end
            if (c == 13) check("fp io_gnt c13", 32'(io_gnt_w[1]), 32'd1);
            if (c == 14) begin
                check("fp io_ack c14", 32'(io_ack_w[1]), 32'd1);
                io_req = 1'b0; io_cmd = MNONE;
            end
        end
        repeat (8) nxt();

        // LAT = 3 cpu read on instance 2.
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_cmd = MREAD; cpu_addr = 9'h005;
        for (int c = 1; c <= 4; c++) begin
            nxt();
            if (c <= 3) begin
                check($sformatf("lat3 mem_cmd c%0d", c), 32'(mem_cmd_w[2]), 32'(MREAD));
                check($sformatf("lat3 mem_addr c%0d", c), 32'(mem_addr_w[2]), 32'h005);
            end else begin
                check("lat3 cpu_ack c4", 32'(cpu_ack_w[2]), 32'd1);
                check("lat3 mem_cmd c4", 32'(mem_cmd_w[2]), 32'(MNONE));
                check("lat3 cpu_rdata c4", 32'(cpu_rdata_w[2]), 32'hABCD);
                cpu_req = 1'b0; cpu_cmd = MNONE;
            end
        end
        repeat (4) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
